// File: rtl/fir_out_requant.sv
// fir_out_requant: decimate, round/saturate and FIFO-buffer the FIR output.
// Optional feature macro: FIR_REQ_STATS_EN (adds the saturation counter port sat_count).
module fir_out_requant #(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned SHIFT = 15,
  parameter int unsigned DECIM = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [IN_W-1:0]          in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
`ifdef FIR_REQ_STATS_EN
  ,
  output logic [15:0]              sat_count
`endif
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = AW + 1;
  localparam int unsigned PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned XW    = IN_W + 1;

  localparam logic signed [XW-1:0] RND    = XW'(1) << (SHIFT - 1);
  localparam logic signed [XW-1:0] SAT_HI = XW'((64'd1 << (OUT_W - 1)) - 64'd1);
  localparam logic signed [XW-1:0] SAT_LO = ~SAT_HI;

  logic [PH_W-1:0]         phase;
  logic                    keep;
  logic signed [XW-1:0]    x_ext;
  logic signed [XW-1:0]    x_rnd;
  logic signed [XW-1:0]    r;
  logic                    sat_hi;
  logic                    sat_lo;
  logic [OUT_W-1:0]        q_data;

  logic                    pipe_valid;
  logic [OUT_W-1:0]        pipe_data;

  logic [OUT_W-1:0]        mem [DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [AW-1:0]           rd_ptr_nx;
  logic [LVL_W-1:0]        level_nx;
  logic [OUT_W-1:0]        head_nx;
  logic                    pop;
  logic                    full;
  logic                    wr_en;

  // Decimator keep decision and round-half-up / saturate arithmetic.
  always_comb begin
    keep   = in_valid && (phase == '0);
    x_ext  = {in_data[IN_W-1], in_data};
    x_rnd  = x_ext + RND;
    r      = x_rnd >>> SHIFT;
    sat_hi = (r > SAT_HI);
    sat_lo = (r < SAT_LO);
    if (sat_hi)      q_data = SAT_HI[OUT_W-1:0];
    else if (sat_lo) q_data = SAT_LO[OUT_W-1:0];
    else             q_data = r[OUT_W-1:0];
  end

  // Phase counter advances only on accepted input samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (in_valid) begin
      phase <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + PH_W'(1);
    end
  end

  // Stage 1 register: holds the requantised kept sample for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid <= 1'b0;
      pipe_data  <= '0;
    end else begin
      pipe_valid <= keep;
      if (keep) pipe_data <= q_data;
    end
  end

  // FIFO control: a write into a full FIFO is allowed only alongside a pop.
  always_comb begin
    pop       = out_valid && out_ready;
    full      = (level == LVL_W'(DEPTH));
    wr_en     = pipe_valid && (!full || pop);
    rd_ptr_nx = pop ? rd_ptr + AW'(1) : rd_ptr;
    level_nx  = level + LVL_W'(wr_en) - LVL_W'(pop);
    head_nx   = out_data;
    if (level_nx != '0) begin
      head_nx = (wr_en && (wr_ptr == rd_ptr_nx)) ? pipe_data : mem[rd_ptr_nx];
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= pipe_data;
  end

  // Pointers, occupancy, registered head-of-FIFO and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr    <= rd_ptr_nx;
      level     <= level_nx;
      out_valid <= (level_nx != '0);
      out_data  <= head_nx;
      if (pipe_valid && full && !pop) overflow <= 1'b1;
    end
  end

`ifdef FIR_REQ_STATS_EN
  // Saturating count of kept samples that clipped, dropped or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (keep && (sat_hi || sat_lo) && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fir_out_requant.sv
// Scoreboard bench for fir_out_requant: one instance with DECIM=1, one with DECIM=4,
// both driven by the same stimulus and checked against a queue-based reference model.
module tb_fir_out_requant;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned SHIFT = 15;
  localparam int          DEC1  = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        ov0, ov1, of0, of1;
  logic [15:0] od0, od1;
  logic [2:0]  lv0, lv1;
`ifdef FIR_REQ_STATS_EN
  logic [15:0] sc0, sc1;
`endif

  int checks = 0;
  int errors = 0;

  fir_out_requant #(.IN_W(32), .OUT_W(16), .SHIFT(SHIFT), .DECIM(1), .DEPTH(DEPTH)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .level(lv0), .overflow(of0)
`ifdef FIR_REQ_STATS_EN
    , .sat_count(sc0)
`endif
  );

  fir_out_requant #(.IN_W(32), .OUT_W(16), .SHIFT(SHIFT), .DECIM(DEC1), .DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .level(lv1), .overflow(of1)
`ifdef FIR_REQ_STATS_EN
    , .sat_count(sc1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference rounding: floor((v + 2^(SHIFT-1)) / 2^SHIFT) with plain integer maths.
  function automatic longint rq_raw(input logic [31:0] d);
    longint num;
    longint div;
    div = longint'(1) << SHIFT;
    num = longint'($signed(d)) + (div / 2);
    if (num >= 0) return num / div;
    return -((-num + div - 1) / div);
  endfunction

  function automatic logic [15:0] rq_sat(input longint r);
    if (r > 32767)  return 16'h7FFF;
    if (r < -32768) return 16'h8000;
    return r[15:0];
  endfunction

  // Reference model state: occupancy, pipeline slot, overflow, saturation count.
  int          mocc0, mocc1;
  bit          pv0, pv1;
  logic [15:0] pd0, pd1;
  int          ph1;
  bit          mof0, mof1;
  int          msc0, msc1;
  longint      mr;
  bit          mpop0, mpop1;
  logic [15:0] sb0[$];
  logic [15:0] sb1[$];

  // Model step on each edge: FIFO accept/drop decision, then capture the new sample.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mocc0 = 0; mocc1 = 0; pv0 = 0; pv1 = 0; ph1 = 0;
      mof0 = 0; mof1 = 0; msc0 = 0; msc1 = 0;
    end else begin
      mpop0 = (mocc0 > 0) && out_ready;
      mpop1 = (mocc1 > 0) && out_ready;
      if (mpop0) mocc0--;
      if (mpop1) mocc1--;
      if (pv0) begin
        if (mocc0 < DEPTH) begin sb0.push_back(pd0); mocc0++; end
        else mof0 = 1;
      end
      if (pv1) begin
        if (mocc1 < DEPTH) begin sb1.push_back(pd1); mocc1++; end
        else mof1 = 1;
      end
      pv0 = 0;
      pv1 = 0;
      if (in_valid) begin
        mr  = rq_raw(in_data);
        pv0 = 1;
        pd0 = rq_sat(mr);
        if ((mr > 32767 || mr < -32768) && msc0 < 65535) msc0++;
        if (ph1 == 0) begin
          pv1 = 1;
          pd1 = pd0;
          if ((mr > 32767 || mr < -32768) && msc1 < 65535) msc1++;
        end
        ph1 = (ph1 + 1) % DEC1;
      end
    end
  end

  logic [15:0] last0, last1;
  int          pops1;

  // Monitor: compare status every cycle, pop the scoreboard on each handshake.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb0.delete();
      sb1.delete();
      last0 = 16'h0;
      last1 = 16'h0;
    end else if (!clk) begin
      chk("out_valid0", 32'(ov0), 32'(mocc0 > 0));
      chk("level0", 32'(lv0), 32'(mocc0));
      chk("overflow0", 32'(of0), 32'(mof0));
      chk("out_valid1", 32'(ov1), 32'(mocc1 > 0));
      chk("level1", 32'(lv1), 32'(mocc1));
      chk("overflow1", 32'(of1), 32'(mof1));
`ifdef FIR_REQ_STATS_EN
      chk("sat_count0", 32'(sc0), 32'(msc0));
      chk("sat_count1", 32'(sc1), 32'(msc1));
`endif
      if (ov0) begin
        if (sb0.size() == 0) chk("sb0_empty", 32'(ov0), 32'h0);
        else if (out_ready) begin last0 = sb0.pop_front(); chk("data0", 32'(od0), 32'(last0)); end
        else chk("head0", 32'(od0), 32'(sb0[0]));
      end else begin
        chk("hold0", 32'(od0), 32'(last0));
      end
      if (ov1) begin
        if (sb1.size() == 0) chk("sb1_empty", 32'(ov1), 32'h0);
        else if (out_ready) begin last1 = sb1.pop_front(); chk("data1", 32'(od1), 32'(last1)); pops1++; end
        else chk("head1", 32'(od1), 32'(sb1[0]));
      end else begin
        chk("hold1", 32'(od1), 32'(last1));
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] d, input logic rdy);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
  endtask

  // Asynchronous reset between edges; outputs must clear with no clock edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid0", 32'(ov0), 32'h0);
    chk("rst_level0", 32'(lv0), 32'h0);
    chk("rst_overflow0", 32'(of0), 32'h0);
    chk("rst_out_data0", 32'(od0), 32'h0);
    chk("rst_out_valid1", 32'(ov1), 32'h0);
    chk("rst_level1", 32'(lv1), 32'h0);
    chk("rst_overflow1", 32'(of1), 32'h0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rnd_data();
    logic [31:0] r;
    logic [31:0] edges [6];
    edges = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h3FFF_C000, 32'h3FFF_BFFF, 32'hBFFF_C000, 32'hBFFF_BFFF};
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       return r;
      1:       return {{15{r[16]}}, r[16:0]};
      2:       return edges[$urandom_range(0, 5)];
      default: return {{2{r[31]}}, r[29:0]};
    endcase
  endfunction

  logic [31:0] rnd_t [4];
  logic [31:0] sat_t [4];
  int          p_before;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b1; pops1 = 0;
    rnd_t = '{32'h0000_4000, 32'h0000_3FFF, 32'hFFFF_C000, 32'hFFFF_BFFF};
    sat_t = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h3FFF_8000, 32'h3FFF_C000};
    do_reset();

    // Rounding and saturation boundaries.
    foreach (rnd_t[i]) drive(1'b1, rnd_t[i], 1'b1);
    foreach (sat_t[i]) drive(1'b1, sat_t[i], 1'b1);
    repeat (4) drive(1'b0, 32'h0, 1'b1);

    // Decimation by 4 with gaps in in_valid.
    do_reset();
    p_before = pops1;
    for (int n = 1; n <= 8; n++) begin
      drive(1'b1, 32'(n) << 15, 1'b1);
      if (n % 3 == 0) drive(1'b0, 32'h0, 1'b1);
    end
    repeat (4) drive(1'b0, 32'h0, 1'b1);
    chk("decim_outputs", 32'(pops1 - p_before), 32'd2);

    // Back-pressure: six samples into a four-entry FIFO.
    do_reset();
    for (int n = 1; n <= 6; n++) drive(1'b1, 32'(n) << 15, 1'b0);
    repeat (2) drive(1'b0, 32'h0, 1'b0);
    #1;
    chk("bp_level", 32'(lv0), 32'd4);
    chk("bp_overflow", 32'(of0), 32'h1);
    repeat (6) drive(1'b0, 32'h0, 1'b1);
    #1;
    chk("bp_drained", 32'(ov0), 32'h0);
    chk("bp_sticky", 32'(of0), 32'h1);

    // Full FIFO with simultaneous write and pop.
    do_reset();
    for (int n = 1; n <= 5; n++) drive(1'b1, 32'(n) << 15, 1'b0);
    for (int n = 6; n <= 8; n++) drive(1'b1, 32'(n) << 15, 1'b1);
    #1;
    chk("full_level", 32'(lv0), 32'd4);
    chk("full_overflow", 32'(of0), 32'h0);
    repeat (6) drive(1'b0, 32'h0, 1'b1);

    // Async reset mid-burst with three entries buffered, then first-sample latency.
    do_reset();
    for (int n = 1; n <= 3; n++) drive(1'b1, 32'(n) << 15, 1'b0);
    repeat (2) drive(1'b0, 32'h0, 1'b0);
    #1;
    chk("pre_rst_level", 32'(lv0), 32'd3);
    do_reset();
    drive(1'b1, 32'h0002_8000, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    repeat (3) drive(1'b0, 32'h0, 1'b1);

    // Randomised traffic with random back-pressure.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 9) < 6), rnd_data(), 1'($urandom_range(0, 3) != 0));
    end
    repeat (10) drive(1'b0, 32'h0, 1'b1);

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
